// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the requester-side handshake and the FIFO write-port signals of
//   fifo_wr_arbiter so that the arbiter and its environment connect through
//   one port.
//
//   Signals
//     req     [NUM_REQ]         requester i has data pending (level)
//     valid   [NUM_REQ]         beat on data[i] valid this cycle
//     last    [NUM_REQ]         beat on data[i] is last of its packet
//     data    [NUM_REQ*DATA_W]  requester i beat at [i*DATA_W +: DATA_W]
//     full                      FIFO full flag from the write-side pointer logic
//     gnt     [NUM_REQ]         registered one-hot grant
//     ack     [NUM_REQ]         beat of requester i accepted this cycle
//     w_en                      FIFO write enable
//     w_data  [DATA_W]          FIFO write data
//     busy                      arbiter not idle
//
//   Modports
//     master : requesters plus FIFO full flag (drives inputs, observes outputs)
//     slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        valid;
   logic [NUM_REQ-1:0]        last;
   logic [NUM_REQ*DATA_W-1:0] data;
   logic                      full;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        ack;
   logic                      w_en;
   logic [DATA_W-1:0]         w_data;
   logic                      busy;

   modport master (
      output req, valid, last, data, full,
      input  gnt, ack, w_en, w_data, busy
   );

   modport slave (
      input  req, valid, last, data, full,
      output gnt, ack, w_en, w_data, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin burst arbiter sharing the async FIFO write port among NUM_REQ
//   requesters in the w_clk domain. One requester is granted at a time; its
//   beats are forwarded as w_en/w_data, nothing is written while the FIFO is
//   full, and each grant is bounded both in accepted beats (BURST_MAX) and in
//   consecutive idle granted cycles (TIMEOUT).
//
//   Ports
//     w_clk  in   write-domain clock
//     n_rst  in   asynchronous active-low reset
//     bus    slave modport of fifo_wr_arbiter_if:
//              req/valid/last/data/full in, gnt/ack/w_en/w_data/busy out
//
//   gnt and busy come straight from registers; ack, w_en and w_data are
//   combinational from the registered grant and the current inputs so that a
//   beat can be written in the very first granted cycle.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int DATA_W    = 8,
   parameter int BURST_MAX = 16,
   parameter int TIMEOUT   = 8
) (
   input  logic             w_clk,
   input  logic             n_rst,
   fifo_wr_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int BC_W  = $clog2(BURST_MAX + 1);
   localparam int IC_W  = $clog2(TIMEOUT + 1);

   localparam logic [BC_W-1:0]  BEAT_LAST = BC_W'(BURST_MAX - 1);
   localparam logic [IC_W-1:0]  IDLE_LAST = IC_W'(TIMEOUT - 1);
   // Pointer starts on the highest index so requester 0 wins the first arbitration.
   localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_END   = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [NUM_REQ-1:0]  gnt_r, gnt_s;
   logic [IDX_W-1:0]    g_idx_r, g_idx_s;
   logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_s;
   logic [BC_W-1:0]     beat_cnt_r, beat_cnt_s;
   logic [IC_W-1:0]     idle_cnt_r, idle_cnt_s;

   logic                win_found_s;
   logic [IDX_W-1:0]    win_idx_s;
   logic                cur_req_s;
   logic                cur_valid_s;
   logic                cur_last_s;
   logic                accept_s;
   logic                burst_end_s;
   logic [DATA_W-1:0]   gdata_s;

   // Round-robin search starting just after ptr; returns {found, index}.
   function automatic logic [IDX_W:0] rr_pick(
      input logic [NUM_REQ-1:0] req_v,
      input logic [IDX_W-1:0]   ptr
   );
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] cand;
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!found && req_v[cand]) begin
            found = 1'b1;
            idx   = cand;
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   // One-hot vector with bit idx set.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1'b1) << idx;
   endfunction

   // Arbitration winner among currently requesting inputs.
   always_comb begin
      {win_found_s, win_idx_s} = rr_pick(bus.req, rr_ptr_r);
   end

   // Signals of the requester currently holding the grant.
   always_comb begin
      cur_req_s   = bus.req[g_idx_r];
      cur_valid_s = bus.valid[g_idx_r];
      cur_last_s  = bus.last[g_idx_r];
      gdata_s     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gdata_s = (g_idx_r == IDX_W'(i)) ? bus.data[i*DATA_W +: DATA_W] : gdata_s;
      end
   end

   // Beat acceptance: granted, valid and FIFO not full; gnt_r is only non-zero in BURST.
   always_comb begin
      accept_s = gnt_r[g_idx_r] & cur_valid_s & ~bus.full;
   end

   // Burst termination; all causes are evaluated in the same cycle.
   always_comb begin
      if (state_r == ST_BURST) begin
         burst_end_s = (accept_s & cur_last_s)
                     | (accept_s & (beat_cnt_r == BEAT_LAST))
                     | (~cur_req_s & ~accept_s)
                     | (~cur_valid_s & ~bus.full & (idle_cnt_r == IDLE_LAST));
      end else begin
         burst_end_s = 1'b0;
      end
   end

   // Next-state and next-register values.
   always_comb begin
      state_s    = state_r;
      gnt_s      = gnt_r;
      g_idx_s    = g_idx_r;
      rr_ptr_s   = rr_ptr_r;
      beat_cnt_s = beat_cnt_r;
      idle_cnt_s = idle_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (win_found_s) begin
               state_s    = ST_BURST;
               gnt_s      = onehot(win_idx_s);
               g_idx_s    = win_idx_s;
               beat_cnt_s = '0;
               idle_cnt_s = '0;
            end else begin
               gnt_s      = '0;
            end
         end
         ST_BURST: begin
            // A full stall (valid & full) leaves both counters untouched.
            if (accept_s) begin
               beat_cnt_s = beat_cnt_r + BC_W'(1'b1);
               idle_cnt_s = '0;
            end else if (~cur_valid_s & ~bus.full & ~burst_end_s) begin
               idle_cnt_s = idle_cnt_r + IC_W'(1'b1);
            end else begin
               idle_cnt_s = idle_cnt_r;
            end
            if (burst_end_s) begin
               state_s = ST_END;
               gnt_s   = '0;
            end else begin
               state_s = ST_BURST;
            end
         end
         ST_END: begin
            // Last-granted index becomes lowest priority for the next arbitration.
            rr_ptr_s = g_idx_r;
            gnt_s    = '0;
            state_s  = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            gnt_s   = '0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge w_clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r    <= ST_IDLE;
         gnt_r      <= '0;
         g_idx_r    <= '0;
         rr_ptr_r   <= PTR_RST;
         beat_cnt_r <= '0;
         idle_cnt_r <= '0;
      end else begin
         state_r    <= state_s;
         gnt_r      <= gnt_s;
         g_idx_r    <= g_idx_s;
         rr_ptr_r   <= rr_ptr_s;
         beat_cnt_r <= beat_cnt_s;
         idle_cnt_r <= idle_cnt_s;
      end
   end

   // Output drive; write data is zero whenever nobody holds the grant.
   always_comb begin
      bus.gnt  = gnt_r;
      bus.w_en = accept_s;
      bus.busy = (state_r != ST_IDLE);
      if (accept_s) begin
         bus.ack = onehot(g_idx_r);
      end else begin
         bus.ack = '0;
      end
      if (|gnt_r) begin
         bus.w_data = gdata_s;
      end else begin
         bus.w_data = '0;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NUM_REQ=2, DATA_W=8, BURST_MAX=16,
//   TIMEOUT=8). Inputs change 1 time unit after the rising edge and outputs
//   are sampled 2 units later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
   localparam int NUM_REQ   = 2;
   localparam int DATA_W    = 8;
   localparam int BURST_MAX = 16;
   localparam int TIMEOUT   = 8;

   logic w_clk = 1'b0;
   logic n_rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .DATA_W   (DATA_W),
      .BURST_MAX(BURST_MAX),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .w_clk(w_clk),
      .n_rst(n_rst),
      .bus  (bus)
   );

   always #5 w_clk = ~w_clk;

   task automatic step();
      @(posedge w_clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_inputs();
      bus.req   = 2'b00;
      bus.valid = 2'b00;
      bus.last  = 2'b00;
      bus.data  = 16'h0000;
      bus.full  = 1'b0;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      clear_inputs();
      step();
      step();
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      n_rst     = 1'b0;
      clear_inputs();
      bus.req   = 2'b11;
      bus.valid = 2'b11;
      bus.data  = 16'hA55A;
      #3;
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt); end
      checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", bus.ack); end
      checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en got=%b exp=0", bus.w_en); end
      checks++; if (bus.w_data !== 8'h00) begin errors++; $display("FAIL reset_w_data got=%h exp=00", bus.w_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      step();
      step();
      clear_inputs();
      n_rst = 1'b1;
      step();
      settle();
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL post_reset_idle_gnt got=%b exp=00", bus.gnt); end
   endtask

   task automatic test_single_burst();
      logic [7:0] exp_d;
      do_reset();
      bus.req   = 2'b01;
      bus.valid = 2'b01;
      bus.data  = 16'h0011;
      settle();
      checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL single_idle_w_en got=%b exp=0", bus.w_en); end
      step();
      for (int b = 0; b < 4; b++) begin
         exp_d = 8'h11 + 8'(b);
         bus.data[7:0] = exp_d;
         bus.last      = (b == 3) ? 2'b01 : 2'b00;
         settle();
         checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL single_gnt beat%0d got=%b exp=01", b, bus.gnt); end
         checks++; if (bus.w_en !== 1'b1) begin errors++; $display("FAIL single_w_en beat%0d got=%b exp=1", b, bus.w_en); end
         checks++; if (bus.w_data !== exp_d) begin errors++; $display("FAIL single_w_data beat%0d got=%h exp=%h", b, bus.w_data, exp_d); end
         checks++; if (bus.ack !== 2'b01) begin errors++; $display("FAIL single_ack beat%0d got=%b exp=01", b, bus.ack); end
         step();
      end
      clear_inputs();
      settle();
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL single_end_gnt got=%b exp=00", bus.gnt); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_end_busy got=%b exp=1", bus.busy); end
      step();
      settle();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      logic [7:0] exp_d;
      do_reset();
      bus.req   = 2'b11;
      bus.valid = 2'b11;
      step();
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         for (int b = 0; b < 3; b++) begin
            bus.data = {8'hB0 + 8'(b), 8'hA0 + 8'(b)};
            bus.last = (b == 2) ? 2'b11 : 2'b00;
            exp_d    = (k % 2 == 0) ? (8'hA0 + 8'(b)) : (8'hB0 + 8'(b));
            settle();
            checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL rr_gnt burst%0d beat%0d got=%b exp=%b", k, b, bus.gnt, exp_g); end
            checks++; if (bus.w_data !== exp_d) begin errors++; $display("FAIL rr_w_data burst%0d beat%0d got=%h exp=%h", k, b, bus.w_data, exp_d); end
            step();
         end
         settle();
         checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rr_end_gnt burst%0d got=%b exp=00", k, bus.gnt); end
         checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL rr_end_w_en burst%0d got=%b exp=0", k, bus.w_en); end
         if (k == 3) clear_inputs();
         step();
         settle();
         checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rr_idle_gnt burst%0d got=%b exp=00", k, bus.gnt); end
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_idle_busy burst%0d got=%b exp=0", k, bus.busy); end
         step();
      end
      clear_inputs();
   endtask

   task automatic test_preempt();
      int         sent0;
      int         run;
      int         runs[$];
      logic [1:0] gseq[$];
      logic [1:0] prev_gnt;
      logic [7:0] exp_d;
      logic [1:0] exp_seq[5];
      bit         done;
      sent0    = 0;
      run      = 0;
      prev_gnt = 2'b00;
      done     = 1'b0;
      exp_seq  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
      do_reset();
      bus.req[1]       = 1'b1;
      bus.valid[1]     = 1'b1;
      bus.last[1]      = 1'b1;
      bus.data[15:8]   = 8'hC5;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         exp_d         = 8'h40 + 8'(sent0);
         bus.req[0]    = (sent0 < 40);
         bus.valid[0]  = (sent0 < 40);
         bus.last[0]   = 1'b0;
         bus.data[7:0] = exp_d;
         settle();
         if (bus.gnt != prev_gnt && bus.gnt != 2'b00) gseq.push_back(bus.gnt);
         if (bus.gnt == 2'b01 && sent0 < 40) begin
            checks++; if (bus.w_en !== 1'b1) begin errors++; $display("FAIL preempt_w_en cyc%0d got=%b exp=1", cyc, bus.w_en); end
         end
         if (bus.ack[0] === 1'b1) begin
            checks++; if (bus.w_data !== exp_d) begin errors++; $display("FAIL preempt_w_data beat%0d got=%h exp=%h", sent0, bus.w_data, exp_d); end
            sent0++;
            run++;
         end
         if (prev_gnt == 2'b01 && bus.gnt == 2'b00) begin
            runs.push_back(run);
            run = 0;
         end
         prev_gnt = bus.gnt;
         if (runs.size() == 3) done = 1'b1;
         else step();
      end
      clear_inputs();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL preempt_timeout got=%0d runs exp=3", runs.size()); end
      checks++; if (sent0 !== 40) begin errors++; $display("FAIL preempt_total got=%0d exp=40", sent0); end
      if (runs.size() == 3) begin
         checks++; if (runs[0] !== 16) begin errors++; $display("FAIL preempt_run0 got=%0d exp=16", runs[0]); end
         checks++; if (runs[1] !== 16) begin errors++; $display("FAIL preempt_run1 got=%0d exp=16", runs[1]); end
         checks++; if (runs[2] !== 8) begin errors++; $display("FAIL preempt_run2 got=%0d exp=8", runs[2]); end
      end
      checks++; if (gseq.size() < 5) begin errors++; $display("FAIL preempt_gseq_len got=%0d exp>=5", gseq.size()); end
      for (int i = 0; i < 5 && i < gseq.size(); i++) begin
         checks++; if (gseq[i] !== exp_seq[i]) begin errors++; $display("FAIL preempt_gseq%0d got=%b exp=%b", i, gseq[i], exp_seq[i]); end
      end
      step();
      step();
   endtask

   task automatic test_full_stall();
      logic [7:0] exp_d;
      do_reset();
      bus.req   = 2'b01;
      bus.valid = 2'b01;
      step();
      for (int b = 0; b < 16; b++) begin
         exp_d = 8'h60 + 8'(b);
         bus.data[7:0] = exp_d;
         if (b == 1) begin
            bus.full = 1'b1;
            for (int s = 0; s < 5; s++) begin
               settle();
               checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL stall_w_en cyc%0d got=%b exp=0", s, bus.w_en); end
               checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL stall_ack cyc%0d got=%b exp=00", s, bus.ack); end
               checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL stall_gnt cyc%0d got=%b exp=01", s, bus.gnt); end
               step();
            end
            bus.full = 1'b0;
         end
         settle();
         checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL stall_burst_gnt beat%0d got=%b exp=01", b, bus.gnt); end
         checks++; if (bus.w_data !== exp_d) begin errors++; $display("FAIL stall_w_data beat%0d got=%h exp=%h", b, bus.w_data, exp_d); end
         checks++; if (bus.w_en !== 1'b1) begin errors++; $display("FAIL stall_beat_w_en beat%0d got=%b exp=1", b, bus.w_en); end
         step();
      end
      settle();
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL stall_preempt_gnt got=%b exp=00", bus.gnt); end
      clear_inputs();
      step();
      step();
   endtask

   task automatic test_timeout();
      do_reset();
      bus.req = 2'b10;
      step();
      bus.req   = 2'b11;
      bus.valid = 2'b00;
      for (int c = 1; c <= TIMEOUT; c++) begin
         settle();
         checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL timeout_hold_gnt cyc%0d got=%b exp=10", c, bus.gnt); end
         step();
      end
      settle();
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL timeout_revoke_gnt got=%b exp=00", bus.gnt); end
      step();
      bus.valid     = 2'b01;
      bus.last      = 2'b01;
      bus.data[7:0] = 8'h77;
      settle();
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL timeout_idle_gnt got=%b exp=00", bus.gnt); end
      step();
      settle();
      checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL timeout_next_gnt got=%b exp=01", bus.gnt); end
      checks++; if (bus.w_data !== 8'h77) begin errors++; $display("FAIL timeout_req0_data got=%h exp=77", bus.w_data); end
      step();
      step();
      step();
      settle();
      checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL timeout_regrant_gnt got=%b exp=10", bus.gnt); end
      clear_inputs();
      step();
      step();
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.req   = 2'b01;
      bus.valid = 2'b01;
      step();
      for (int b = 0; b < 5; b++) begin
         bus.data[7:0] = 8'h90 + 8'(b);
         settle();
         checks++; if (bus.w_en !== 1'b1) begin errors++; $display("FAIL areset_pre_w_en beat%0d got=%b exp=1", b, bus.w_en); end
         if (b < 4) step();
      end
      #1;
      n_rst = 1'b0;
      #1;
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL areset_gnt got=%b exp=00", bus.gnt); end
      checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL areset_ack got=%b exp=00", bus.ack); end
      checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL areset_w_en got=%b exp=0", bus.w_en); end
      checks++; if (bus.w_data !== 8'h00) begin errors++; $display("FAIL areset_w_data got=%h exp=00", bus.w_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
      bus.req   = 2'b11;
      bus.valid = 2'b00;
      step();
      step();
      n_rst = 1'b1;
      settle();
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL areset_idle_gnt got=%b exp=00", bus.gnt); end
      step();
      settle();
      checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL areset_first_gnt got=%b exp=01", bus.gnt); end
      clear_inputs();
      step();
      step();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_burst();
      test_round_robin();
      test_preempt();
      test_full_stall();
      test_timeout();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
